// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file widths and the writeback request record.
package regfile_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_req_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending mul/div BUSY bits and the issue-conflict pulse.
module wb_scoreboard
  import regfile_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic                  i_clr,
  input  logic [REG_ADDR_W-1:0] i_clr_addr,
  output logic [NUM_REGS-1:0]   o_busy,
  output logic                  o_conflict
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  logic                r_conflict;
  logic                w_issue;
  always_comb begin
    w_issue = i_issue_valid && i_issue_rd != ZERO_REG;
    w_set   = w_issue ? NUM_REGS'(1) << i_issue_rd : '0;
    w_clr   = i_clr ? NUM_REGS'(1) << i_clr_addr : '0;
  end
  // Set is OR-ed after the clear so a same-edge reissue keeps the bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy     <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_busy     <= ((r_busy & ~w_clr) | w_set) & ~NUM_REGS'(1);
      r_conflict <= w_issue && r_busy[i_issue_rd];
    end
  end
  assign o_busy     = r_busy;
  assign o_conflict = r_conflict;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between core writeback
// (priority) and a buffered, starvation-bounded mul/div result port.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WB0_VALID,
  input  logic [REG_ADDR_W-1:0] WB0_ADDR,
  input  logic [XLEN-1:0]       WB0_DATA,
  output logic                  WB0_READY,
  input  logic                  WB1_VALID,
  input  logic [REG_ADDR_W-1:0] WB1_ADDR,
  input  logic [XLEN-1:0]       WB1_DATA,
  output logic                  WB1_READY,
  input  logic                  ISSUE_VALID,
  input  logic [REG_ADDR_W-1:0] ISSUE_RD,
  output logic                  ISSUE_CONFLICT,
  output logic                  WE3,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3,
  output logic [NUM_REGS-1:0]   BUSY
);
  localparam logic [3:0] W_MAX = 4'(MAX_WAIT);
  wb_req_t    r_hold;
  logic [3:0] r_wait_cnt;
  logic       w_force;
  logic       w_grant0;
  logic       w_grant1;
  always_comb begin
    w_force   = r_hold.valid && r_wait_cnt == W_MAX;
    w_grant1  = r_hold.valid && (!WB0_VALID || w_force);
    w_grant0  = WB0_VALID && !w_grant1;
    WB0_READY = !w_force;
    WB1_READY = !r_hold.valid || w_grant1;
    A3        = w_grant1 ? r_hold.addr : w_grant0 ? WB0_ADDR : ZERO_REG;
    WD3       = w_grant1 ? r_hold.data : w_grant0 ? WB0_DATA : '0;
    WE3       = (w_grant0 || w_grant1) && A3 != ZERO_REG;
  end
  // Draining and refilling on the same edge gives port 1 one result per cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold     <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (WB1_VALID && WB1_READY)
        r_hold <= '{valid: 1'b1, addr: WB1_ADDR, data: WB1_DATA};
      else if (w_grant1)
        r_hold.valid <= 1'b0;
      r_wait_cnt <= (!r_hold.valid || w_grant1) ? 4'd0 :
                    (r_wait_cnt == W_MAX) ? r_wait_cnt : r_wait_cnt + 4'd1;
    end
  end
  wb_scoreboard u_sb (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_issue_valid(ISSUE_VALID),
    .i_issue_rd   (ISSUE_RD),
    .i_clr        (w_grant1),
    .i_clr_addr   (r_hold.addr),
    .o_busy       (BUSY),
    .o_conflict   (ISSUE_CONFLICT)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed plus random stimulus against a queue-based
// reference model; a negedge monitor pops expected outputs and compares.
module tb_regfile_wb_arbiter;
  localparam int MW = 4;
  logic        CLK = 0, RST = 1;
  logic        WB0_VALID = 0, WB1_VALID = 0, ISSUE_VALID = 0;
  logic [4:0]  WB0_ADDR = 0, WB1_ADDR = 0, ISSUE_RD = 0;
  logic [31:0] WB0_DATA = 0, WB1_DATA = 0;
  logic        WB0_READY, WB1_READY, ISSUE_CONFLICT, WE3;
  logic [4:0]  A3;
  logic [31:0] WD3, BUSY;

  regfile_wb_arbiter #(.MAX_WAIT(MW)) dut (
    .CLK(CLK), .RST(RST),
    .WB0_VALID(WB0_VALID), .WB0_ADDR(WB0_ADDR), .WB0_DATA(WB0_DATA), .WB0_READY(WB0_READY),
    .WB1_VALID(WB1_VALID), .WB1_ADDR(WB1_ADDR), .WB1_DATA(WB1_DATA), .WB1_READY(WB1_READY),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .ISSUE_CONFLICT(ISSUE_CONFLICT),
    .WE3(WE3), .A3(A3), .WD3(WD3), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit        we, r0, r1, conf;
    bit [4:0]  a;
    bit [31:0] d, busy;
  } exp_t;
  exp_t exp_q[$];
  int n_cmp = 0, n_bad = 0;

  // Reference model: pending mul/div results, how many cycles the head has lost, pending set.
  bit [4:0]  pend_a[$];
  bit [31:0] pend_d[$];
  int        lost = 0;
  bit        pending_rd[32];
  bit        conf_m = 0;

  task automatic model_reset();
    pend_a.delete(); pend_d.delete();
    lost = 0; conf_m = 0;
    foreach (pending_rd[i]) pending_rd[i] = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("WE3", 32'(WE3), 32'(e.we));
      chk("A3", 32'(A3), 32'(e.a));
      chk("WD3", WD3, e.d);
      chk("WB0_READY", 32'(WB0_READY), 32'(e.r0));
      chk("WB1_READY", 32'(WB1_READY), 32'(e.r1));
      chk("ISSUE_CONFLICT", 32'(ISSUE_CONFLICT), 32'(e.conf));
      chk("BUSY", BUSY, e.busy);
    end
  end

  task automatic step(input bit r, input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                      input bit v1, input bit [4:0] a1, input bit [31:0] d1,
                      input bit iv, input bit [4:0] ir);
    exp_t e;
    bit has, forced, take0, take1;
    @(posedge CLK);
    #1;
    RST = r; WB0_VALID = v0; WB0_ADDR = a0; WB0_DATA = d0;
    WB1_VALID = v1; WB1_ADDR = a1; WB1_DATA = d1; ISSUE_VALID = iv; ISSUE_RD = ir;
    if (r) model_reset();
    has    = pend_a.size() > 0;
    forced = has && lost >= MW;
    take1  = has && (!v0 || forced);
    take0  = v0 && !take1;
    e.r0   = !forced;
    e.r1   = !has || take1;
    e.a    = take1 ? pend_a[0] : take0 ? a0 : 5'd0;
    e.d    = take1 ? pend_d[0] : take0 ? d0 : 32'd0;
    e.we   = (take0 || take1) && e.a != 0;
    e.conf = conf_m;
    e.busy = '0;
    for (int i = 1; i < 32; i++) e.busy[i] = pending_rd[i];
    exp_q.push_back(e);
    if (!r) begin
      conf_m = iv && ir != 0 && pending_rd[ir];
      if (take1) begin
        pending_rd[pend_a[0]] = 0;
        void'(pend_a.pop_front()); void'(pend_d.pop_front());
        lost = 0;
      end else if (has) lost = (lost < MW) ? lost + 1 : MW;
      if (v1 && e.r1) begin
        pend_a.push_back(a1); pend_d.push_back(d1); lost = 0;
      end
      if (iv && ir != 0) pending_rd[ir] = 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 32'h12345678, 0, 0);
    idle(2);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 5'($urandom_range(1, 31)), $urandom, 0, 0);
    idle(2);
    step(0, 1, 1, 32'h11, 1, 9, 32'h99, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 5'(i + 10), $urandom, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    idle(2);
    step(0, 0, 0, 0, 1, 3, 32'h33, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    idle(2);
    step(0, 0, 0, 0, 1, 0, 32'hFFFF, 1, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 0, 0, 1, 12);
    step(0, 1, 2, 32'h22, 1, 12, 32'hCC, 0, 0);
    step(0, 1, 4, 32'h44, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)));
    idle(2);
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the 32x32 register file. It shares the single write port (WE3/A3/WD3) between two requesters: the core writeback path (port 0, priority) and the long-latency multiply/divide unit (port 1, buffered, starvation-bounded). It also tracks destination registers with an outstanding mul/div result and exposes them as BUSY bits for hazard detection. It sits directly in front of the register file's write port.

## Interface
Parameters:
- MAX_WAIT, 4: maximum number of cycles a buffered port-1 result may lose arbitration before it is forced. Legal range 1..15.

Ports (clock and reset first). Clock is CLK; reset is RST, asynchronous and active-high.
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  asynchronous, active-high reset
- WB0_VALID  in  1  core writeback request
- WB0_ADDR  in  5  core destination register
- WB0_DATA  in  32  core write data
- WB0_READY  out  1  core request accepted this cycle
- WB1_VALID  in  1  mul/div result valid
- WB1_ADDR  in  5  mul/div destination register
- WB1_DATA  in  32  mul/div result
- WB1_READY  out  1  mul/div result accepted into the hold buffer
- ISSUE_VALID  in  1  a mul/div operation issued this cycle
- ISSUE_RD  in  5  destination of the issued operation
- ISSUE_CONFLICT  out  1  one-cycle pulse: issue targeted a register already BUSY
- WE3  out  1  register file write enable
- A3  out  5  register file write address
- WD3  out  32  register file write data
- BUSY  out  32  per-register pending mul/div result; bit 0 always 0

## Operation
- Port 1 path: a one-entry hold buffer (hold_valid, hold_addr, hold_data) and a wait counter wait_cnt.
- WB1_READY = !hold_valid || grant1. The buffer loads when WB1_VALID && WB1_READY.
- grant1 = hold_valid && (!WB0_VALID || wait_cnt == MAX_WAIT).
- grant0 = WB0_VALID && !grant1.
- WB0_READY = !(hold_valid && wait_cnt == MAX_WAIT). It is 1 when port 0 is idle and not forced out.
- Write port: selects the hold buffer on grant1 and port 0 on grant0. WE3 = (grant0 || grant1) && A3 != 0.
- A write to x0 is still consumed (handshake completes, buffer drains) but WE3 stays 0.
- When nothing is granted: WE3 = 0, A3 = 0, WD3 = 0.
- wait_cnt is cleared when the hold buffer is empty or on grant1. It increments when hold_valid && !grant1 and saturates at MAX_WAIT.
- Scoreboard: ISSUE_VALID with ISSUE_RD != 0 sets BUSY[ISSUE_RD]; grant1 clears BUSY[hold_addr].
- Simultaneous set and clear of the same bit: set wins.
- ISSUE to x0 is ignored.
- ISSUE to an already-BUSY register: BUSY stays 1, and ISSUE_CONFLICT pulses in the next cycle (registered).
- Port 0 writes never modify BUSY.

## Timing
- Reset: hold_valid=0, wait_cnt=0, BUSY=0, ISSUE_CONFLICT=0. Consequently WE3=0, A3=0, WD3=0, WB1_READY=1, WB0_READY=1.
- WE3/A3/WD3 and both READYs are combinational from current state and inputs. The register file commits on the same CLK edge.
- Port 0 latency: 0 cycles (written on the accepting edge).
- Port 1 latency, acceptance edge to write edge: 1 cycle minimum; MAX_WAIT+1 cycles maximum under continuous port-0 traffic.
- Forced cycle: exactly one cycle with WB0_READY=0 per forced grant.
- Port 1 sustained throughput: 1/cycle when port 0 is idle (buffer drains and refills on the same edge).
- BUSY updates on the edge after ISSUE or grant1. The BUSY bit clears on the same edge the register file is written.
- RST asserted mid-operation: the buffered result is discarded and BUSY clears immediately (asynchronous). The pending write does not occur.

## Structure
- Shared package regfile_pkg holds:
  - XLEN=32
  - REG_ADDR_W=5
  - NUM_REGS=32
  - ZERO_REG=5'd0
  - a wb_req_t struct {valid, addr, data}
- One sub-module, wb_scoreboard, contains the BUSY vector, the set/clear priority and the ISSUE_CONFLICT register. The arbiter and hold buffer stay in the top.

## Test plan
- Reset, then WB0 (addr 5, data 0xDEADBEEF) with port 1 idle → same cycle WE3=1, A3=5, WD3=0xDEADBEEF, WB0_READY=1.
- WB1 (addr 7, 0x12345678) with port 0 idle → next cycle WE3=1, A3=7, WD3=0x12345678.
- Back-to-back WB1 every cycle → one write per cycle; WB1_READY stays 1.
- WB0_VALID held high continuously, WB1 (addr 9) accepted at cycle 0, MAX_WAIT=4:
  - cycles 1–4 write port 0;
  - cycle 5: WB0_READY=0 and A3=9;
  - cycle 6: port 0 resumes.
- ISSUE rd=3, later WB1 addr 3:
  - BUSY[3]=1 from the next cycle until the write edge;
  - a same-cycle ISSUE rd=3 at that write edge leaves BUSY[3]=1.
- ISSUE rd=3 twice → ISSUE_CONFLICT=1 for one cycle.
- WB1 addr 0 → WE3 stays 0 and the buffer drains.
- RST pulsed while the buffer is full → BUSY=0, no write occurs, WB1_READY=1.
